// File: rtl/wb_pkg.sv
// Shared decode constants, funct3/state enums and the load legality check for the write-back stage.
package wb_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_e;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    // A load is rejected when its width is undefined or its address is not naturally aligned.
    function automatic logic load_bad(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LB, LBU: load_bad = 1'b0;
            LH, LHU: load_bad = off[0];
            LW:      load_bad = (off != 2'b00);
            default: load_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Selects the addressed byte/half of a raw load word and sign- or zero-extends it to XLEN.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[{offset, 3'b000} +: 8];
        half_val = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            LB:      data = {{(XLEN-8){byte_val[7]}}, byte_val};
            LH:      data = {{(XLEN-16){half_val[15]}}, half_val};
            LBU:     data = {{(XLEN-8){1'b0}}, byte_val};
            LHU:     data = {{(XLEN-16){1'b0}}, half_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// RV32I write-back stage with integrated register file, load handshake and retire trace.
// Optional macro WB_BYPASS_EN: read ports see the value being written in the same cycle.
module wb_regfile_stage
    import wb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD_PORTS = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic                                  wb_valid_i,
    output logic                                  wb_ready_o,
    input  logic [XLEN-1:0]                       pc_i,
    input  logic [31:0]                           instr_i,
    input  logic                                  rf_we_i,
    input  logic [XLEN-1:0]                       alu_out_i,
    output logic                                  ld_req_o,
    output logic [XLEN-1:0]                       ld_addr_o,
    input  logic                                  ld_rvalid_i,
    input  logic [XLEN-1:0]                       ld_rdata_i,
    input  logic [NRD_PORTS*$clog2(NREGS)-1:0]    rd_addr_i,
    output logic [NRD_PORTS*XLEN-1:0]             rd_data_o,
    output logic                                  ld_err_o,
    output logic                                  retire_valid_o,
    output logic [XLEN-1:0]                       retire_pc_o,
    output logic [31:0]                           retire_instr_o
);

    localparam int AW = $clog2(NREGS);

    // Handshakes: an instruction transfers on any edge where wb_valid_i && wb_ready_o;
    // ld_req_o stays high with a stable ld_addr_o until the edge where ld_rvalid_i is seen.
    wb_state_e       state_q;
    logic [XLEN-1:0] regs_q [NREGS];

    logic [AW-1:0]   ld_rd_q;
    logic [2:0]      ld_f3_q;
    logic [1:0]      ld_off_q;
    logic            ld_we_q;
    logic [XLEN-1:0] ld_pc_q;
    logic [31:0]     ld_instr_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [AW-1:0]   rd;
    logic            accept, is_load, is_jump, ld_bad, ld_start, ld_done;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata, ld_value;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign rd         = instr_i[7 +: AW];
    assign wb_ready_o = (state_q == IDLE);
    assign accept     = wb_valid_i && wb_ready_o;
    assign is_load    = (opcode == OPC_LOAD);
    assign is_jump    = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign ld_bad     = load_bad(funct3, alu_out_i[1:0]);
    assign ld_start   = accept && is_load && !ld_bad;
    assign ld_done    = (state_q == LOAD_WAIT) && ld_rvalid_i;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .funct3 (ld_f3_q),
        .offset (ld_off_q),
        .rdata  (ld_rdata_i),
        .data   (ld_value)
    );

    // At most one write per cycle: either the returning load or a non-load accept.
    always_comb begin
        wen   = 1'b0;
        waddr = rd;
        wdata = is_jump ? pc_i + XLEN'(4) : alu_out_i;
        if (ld_done) begin
            wen   = ld_we_q;
            waddr = ld_rd_q;
            wdata = ld_value;
        end else if (accept && !is_load) begin
            wen = rf_we_i;
        end
        if (waddr == '0) begin
            wen = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            ld_req_o       <= 1'b0;
            ld_addr_o      <= '0;
            ld_err_o       <= 1'b0;
            retire_valid_o <= 1'b0;
            retire_pc_o    <= '0;
            retire_instr_o <= '0;
            ld_rd_q        <= '0;
            ld_f3_q        <= '0;
            ld_off_q       <= '0;
            ld_we_q        <= 1'b0;
            ld_pc_q        <= '0;
            ld_instr_q     <= '0;
        end else begin
            ld_err_o       <= accept && is_load && ld_bad;
            retire_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        state_q    <= LOAD_WAIT;
                        ld_req_o   <= 1'b1;
                        ld_addr_o  <= {alu_out_i[XLEN-1:2], 2'b00};
                        ld_rd_q    <= rd;
                        ld_f3_q    <= funct3;
                        ld_off_q   <= alu_out_i[1:0];
                        ld_we_q    <= rf_we_i;
                        ld_pc_q    <= pc_i;
                        ld_instr_q <= instr_i;
                    end else if (accept) begin
                        retire_valid_o <= 1'b1;
                        retire_pc_o    <= pc_i;
                        retire_instr_o <= instr_i;
                    end
                end
                LOAD_WAIT: begin
                    if (ld_rvalid_i) begin
                        state_q        <= IDLE;
                        ld_req_o       <= 1'b0;
                        retire_valid_o <= 1'b1;
                        retire_pc_o    <= ld_pc_q;
                        retire_instr_o <= ld_instr_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen) begin
            regs_q[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NRD_PORTS; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr_i[p*AW +: AW];
`ifdef WB_BYPASS_EN
        assign rd_data_o[p*XLEN +: XLEN] = (ra == '0) ? '0 :
                                           (wen && ra == waddr) ? wdata : regs_q[ra];
`else
        assign rd_data_o[p*XLEN +: XLEN] = (ra == '0) ? '0 : regs_q[ra];
`endif
    end

endmodule
